pipeline_m: RTL and testbench
=============================

PIPELINE_M -- requirements
Module: pipeline_m

Interface
REQ-001 SHALL provide parameter MEM_WORDS, default 1024, data-memory depth in 32-bit words (power of two).
REQ-002 SHALL provide parameter MEM_BASE, default 32'h00000000, byte address of memory word 0.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have Instr_E  input  32  instruction leaving the E stage.
REQ-005 SHALL have ALUOutput  input  32  E-stage result; the memory address for loads and stores.
REQ-006 SHALL have WriteData_E  input  32  forwarded rt value, used as store data.
REQ-007 SHALL have WriteRd_E  input  5  destination register number.
REQ-008 SHALL have PCPlus4_E  input  32  PC+4 of the E-stage instruction.
REQ-009 SHALL have Flush_M  input  1  turns the next M-stage contents into a bubble.
REQ-010 SHALL have Instr_M, ALUOutput_M, WriteData_M, PCPlus4_M  output  32 each  registered copies of the E-stage inputs.
REQ-011 SHALL have WriteRd_M  output  5  registered copy of WriteRd_E.
REQ-012 SHALL have ReadData_M  output  32  load data (combinational read).
REQ-013 SHALL have MemWrite_M  output  1  high while the M-stage instruction is an enabled store.

Function
REQ-014 SHALL latch all E-stage inputs into the M-stage outputs on each rising clk edge (one-cycle latency).
REQ-015 SHALL load zero into every M-stage register at an edge where Flush_M=1 (Instr_M=0 is a nop), and SHALL discard the E-stage inputs at that edge.
REQ-016 SHALL decode opcodes Instr_M[31:26]: lw 6'b100011, sw 6'b101011. All other opcodes SHALL perform no memory access.
REQ-017 SHALL form the word index as (ALUOutput_M - MEM_BASE)[log2(MEM_WORDS)+1:2]. Out-of-range upper bits SHALL be ignored, so addresses wrap modulo the memory size.
REQ-018 SHALL write WriteData_M to the indexed word on the rising edge when MemWrite_M=1. A store SHALL never write in the same edge at which it is flushed.
REQ-019 SHALL drive ReadData_M combinationally from the indexed word. When the stage does not hold a load, ReadData_M SHALL be 0.
REQ-020 SHALL make a read of the same word during a store cycle return the old value before the edge and the new value after it.
REQ-021 SHALL ignore ALUOutput_M[1:0] for lw/sw; misaligned word addresses SHALL be truncated, not trapped.

Reset
REQ-022 SHALL, while reset=1 and regardless of clk, force Instr_M, ALUOutput_M, WriteData_M, PCPlus4_M and WriteRd_M to 0, and force MemWrite_M to 0.
REQ-023 SHALL clear every data-memory word to 0 on reset, and SHALL block any store pending at reset assertion.
REQ-024 SHALL resume normal latching at the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL honour macro PIPELINE_M_BYTE_EN. When it is defined, the block SHALL additionally decode:
- sb 6'b101000, sh 6'b101001: write the low byte/half into lane ALUOutput_M[1:0] / ALUOutput_M[1]; other lanes unchanged.
- lb 6'b100000, lbu 6'b100100, lh 6'b100001, lhu 6'b100101: select the lane, then sign- or zero-extend to 32 bits.
REQ-026 SHALL, when PIPELINE_M_BYTE_EN is undefined, treat those opcodes as non-memory instructions (REQ-016).

Structure
REQ-027 SHALL place the opcode constants (OP_LW, OP_SW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SB, OP_SH) and the memory-depth default in shared package pipeline_pkg.
REQ-028 SHALL isolate the storage array, byte-lane write enables and async clear in one sub-module dm_mem. pipeline_m SHALL hold the M-stage register and decode.

Verification
REQ-029 SHALL cover sw then lw:
- Edge 1: Instr_E=sw, ALUOutput=32'h0000_0010, WriteData_E=32'hDEAD_BEEF.
- Next edge: lw with the same address.
- Required: ReadData_M=32'hDEAD_BEEF and WriteRd_M equals the latched rt.
REQ-030 SHALL cover flush. Present a sw at 32'h20 with Flush_M=1 at the latching edge. Required: Instr_M=0, MemWrite_M=0, word 8 still 0.
REQ-031 SHALL cover async reset. Assert reset mid-cycle after a store to 32'h4. Required: outputs 0 immediately without a clk edge, and a later lw 32'h4 returns 0.
REQ-032 SHALL cover wrap. With MEM_WORDS=1024, store 32'h1234_5678 at 32'h0000_1004, then lw 32'h4. Required: ReadData_M=32'h1234_5678.
REQ-033 SHALL cover byte access with PIPELINE_M_BYTE_EN defined:
- Store word 32'h0000_0000 at 32'h8, then sb 32'h0000_0080 at 32'h9.
- Required: lb 32'h9 = 32'hFFFF_FF80, lbu 32'h9 = 32'h0000_0080, lw 32'h8 = 32'h0000_8000.
REQ-034 SHALL cover same-word store/load overlap. lw 32'h10 directly follows sw 32'h10 of 32'hA5A5_A5A5 over old value 32'h1. Required: ReadData_M=32'hA5A5_A5A5 in the load's M cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants for the M (memory) pipeline stage: opcode encodings,
// default data-memory depth and the load lane-extension helper.
package pipeline_pkg;

    localparam int MEM_WORDS_DEFAULT = 1024;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    // Pick a byte or half lane out of a memory word and sign/zero-extend it.
    function automatic logic [31:0] lane_extend(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic        is_half,
        input logic        is_signed
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        if (is_half) begin
            r = is_signed ? {{16{h[15]}}, h} : {16'h0000, h};
        end else begin
            r = is_signed ? {{24{b[7]}}, b} : {24'h000000, b};
        end
        return r;
    endfunction

endpackage

// File: rtl/pipeline_m_dm_mem.sv
// Data memory for the M stage: word array with per-byte-lane write enables,
// combinational read port and asynchronous clear of every word on reset.
module dm_mem
    import pipeline_pkg::*;
#(
    parameter int WORDS = MEM_WORDS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(WORDS)-1:0] idx_i,
    input  logic [3:0]               be_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] word_d;

    // Merge the enabled byte lanes of the write data over the current word.
    always_comb begin
        word_d = mem_q[idx_i];
        if (be_i[0]) begin
            word_d[7:0] = wdata_i[7:0];
        end else begin
            word_d[7:0] = mem_q[idx_i][7:0];
        end
        if (be_i[1]) begin
            word_d[15:8] = wdata_i[15:8];
        end else begin
            word_d[15:8] = mem_q[idx_i][15:8];
        end
        if (be_i[2]) begin
            word_d[23:16] = wdata_i[23:16];
        end else begin
            word_d[23:16] = mem_q[idx_i][23:16];
        end
        if (be_i[3]) begin
            word_d[31:24] = wdata_i[31:24];
        end else begin
            word_d[31:24] = mem_q[idx_i][31:24];
        end
    end

    // Storage: cleared asynchronously on reset, merged word written when any lane is enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: 32'h0000_0000};
        end else if (|be_i) begin
            mem_q[idx_i] <= word_d;
        end
    end

    // Read is combinational, so a same-word store becomes visible only after its edge.
    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/pipeline_m.sv
// M pipeline stage: E->M pipeline register with flush, load/store decode
// and the data memory. Optional byte/half access is enabled by defining
// the macro PIPELINE_M_BYTE_EN (sb, sh, lb, lbu, lh, lhu); without it those
// opcodes perform no memory access.
module pipeline_m
    import pipeline_pkg::*;
#(
    parameter int          MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_E,
    input  logic [31:0] ALUOutput,
    input  logic [31:0] WriteData_E,
    input  logic [4:0]  WriteRd_E,
    input  logic [31:0] PCPlus4_E,
    input  logic        Flush_M,
    output logic [31:0] Instr_M,
    output logic [31:0] ALUOutput_M,
    output logic [31:0] WriteData_M,
    output logic [31:0] PCPlus4_M,
    output logic [4:0]  WriteRd_M,
    output logic [31:0] ReadData_M,
    output logic        MemWrite_M
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] instr_d, instr_q;
    logic [31:0] alu_d,   alu_q;
    logic [31:0] wdata_d, wdata_q;
    logic [31:0] pc4_d,   pc4_q;
    logic [4:0]  rd_d,    rd_q;

    logic [5:0]    op_s;
    logic [31:0]   off_s;
    logic [AW-1:0] idx_s;
    logic [3:0]    be_s;
    logic [31:0]   st_data_s;
    logic [31:0]   mem_word_s;
    logic [31:0]   rd_data_s;
    logic          mem_write_s;
    logic          unused_s;

    // Next M-stage contents: a flush replaces the E-stage values with a zero bubble.
    always_comb begin
        if (Flush_M) begin
            instr_d = 32'h0000_0000;
            alu_d   = 32'h0000_0000;
            wdata_d = 32'h0000_0000;
            pc4_d   = 32'h0000_0000;
            rd_d    = 5'd0;
        end else begin
            instr_d = Instr_E;
            alu_d   = ALUOutput;
            wdata_d = WriteData_E;
            pc4_d   = PCPlus4_E;
            rd_d    = WriteRd_E;
        end
    end

    // M-stage pipeline register; reset clears it at once, which also cancels a pending store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= 32'h0000_0000;
            alu_q   <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            rd_q    <= 5'd0;
        end else begin
            instr_q <= instr_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            pc4_q   <= pc4_d;
            rd_q    <= rd_d;
        end
    end

    // Word index: offset from the memory base, byte bits dropped, high bits dropped so accesses wrap.
    assign op_s     = instr_q[31:26];
    assign off_s    = alu_q - MEM_BASE;
    assign idx_s    = off_s[AW+1:2];
    assign unused_s = ^{off_s[31:AW+2], off_s[1:0]};

    // Opcode decode: byte-lane write enables, lane-replicated store data and load result.
    always_comb begin
        be_s        = 4'b0000;
        st_data_s   = wdata_q;
        rd_data_s   = 32'h0000_0000;
        mem_write_s = 1'b0;
        case (op_s)
            OP_LW: begin
                rd_data_s = mem_word_s;
            end
            OP_SW: begin
                be_s        = 4'b1111;
                mem_write_s = 1'b1;
            end
`ifdef PIPELINE_M_BYTE_EN
            OP_SB: begin
                be_s        = 4'b0001 << alu_q[1:0];
                st_data_s   = {4{wdata_q[7:0]}};
                mem_write_s = 1'b1;
            end
            OP_SH: begin
                be_s        = alu_q[1] ? 4'b1100 : 4'b0011;
                st_data_s   = {2{wdata_q[15:0]}};
                mem_write_s = 1'b1;
            end
            OP_LB: begin
                rd_data_s = lane_extend(mem_word_s, alu_q[1:0], 1'b0, 1'b1);
            end
            OP_LBU: begin
                rd_data_s = lane_extend(mem_word_s, alu_q[1:0], 1'b0, 1'b0);
            end
            OP_LH: begin
                rd_data_s = lane_extend(mem_word_s, alu_q[1:0], 1'b1, 1'b1);
            end
            OP_LHU: begin
                rd_data_s = lane_extend(mem_word_s, alu_q[1:0], 1'b1, 1'b0);
            end
`endif
            default: begin
                rd_data_s = 32'h0000_0000;
            end
        endcase
    end

    dm_mem #(
        .WORDS (MEM_WORDS)
    ) u_dm_mem (
        .clk     (clk),
        .reset   (reset),
        .idx_i   (idx_s),
        .be_i    (be_s),
        .wdata_i (st_data_s),
        .rdata_o (mem_word_s)
    );

    assign Instr_M     = instr_q;
    assign ALUOutput_M = alu_q;
    assign WriteData_M = wdata_q;
    assign PCPlus4_M   = pc4_q;
    assign WriteRd_M   = rd_q;
    assign ReadData_M  = rd_data_s;
    assign MemWrite_M  = mem_write_s;

endmodule

// File: tb/tb_pipeline_m.sv
// Bench for pipeline_m: directed scenarios followed by random traffic,
// every cycle compared against a byte-addressed memory model.
module tb_pipeline_m;

    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] MEM_BASE  = 32'h0000_0000;
    localparam int          MEM_BYTES = MEM_WORDS * 4;

    localparam logic [5:0] T_LW  = 6'b100011;
    localparam logic [5:0] T_SW  = 6'b101011;
    localparam logic [5:0] T_LB  = 6'b100000;
    localparam logic [5:0] T_LBU = 6'b100100;
    localparam logic [5:0] T_LH  = 6'b100001;
    localparam logic [5:0] T_LHU = 6'b100101;
    localparam logic [5:0] T_SB  = 6'b101000;
    localparam logic [5:0] T_SH  = 6'b101001;
    localparam logic [5:0] T_ADD = 6'b001000;

    logic        clk;
    logic        reset;
    logic [31:0] instr_e, alu_e, wd_e, pc4_e;
    logic [4:0]  rd_e;
    logic        flush;
    logic [31:0] instr_m, alu_m, wd_m, pc4_m, rdata_m;
    logic [4:0]  rd_m;
    logic        memwrite_m;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [7:0]  mm [MEM_BYTES];
    logic [31:0] m_instr, m_alu, m_wd, m_pc4;
    logic [4:0]  m_rd;

    pipeline_m #(
        .MEM_WORDS (MEM_WORDS),
        .MEM_BASE  (MEM_BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Instr_E     (instr_e),
        .ALUOutput   (alu_e),
        .WriteData_E (wd_e),
        .WriteRd_E   (rd_e),
        .PCPlus4_E   (pc4_e),
        .Flush_M     (flush),
        .Instr_M     (instr_m),
        .ALUOutput_M (alu_m),
        .WriteData_M (wd_m),
        .PCPlus4_M   (pc4_m),
        .WriteRd_M   (rd_m),
        .ReadData_M  (rdata_m),
        .MemWrite_M  (memwrite_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd3, rt, 16'h0000};
    endfunction

    function automatic int baddr(input logic [31:0] a);
        logic [31:0] off;
        off = (a - MEM_BASE) & (MEM_BYTES - 1);
        return int'(off);
    endfunction

    function automatic logic [31:0] word_at(input int a);
        int w;
        w = a & ~3;
        return {mm[w+3], mm[w+2], mm[w+1], mm[w]};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
`ifdef PIPELINE_M_BYTE_EN
        return (op == T_SW) || (op == T_SB) || (op == T_SH);
`else
        return (op == T_SW);
`endif
    endfunction

    function automatic logic [31:0] exp_read();
        int          a;
        logic [7:0]  b;
        logic [15:0] h;
        a = baddr(m_alu);
        b = mm[a];
        h = {mm[(a & ~1) + 1], mm[a & ~1]};
        if (m_instr[31:26] == T_LW) return word_at(a);
`ifdef PIPELINE_M_BYTE_EN
        if (m_instr[31:26] == T_LB)  return {{24{b[7]}}, b};
        if (m_instr[31:26] == T_LBU) return {24'h0, b};
        if (m_instr[31:26] == T_LH)  return {{16{h[15]}}, h};
        if (m_instr[31:26] == T_LHU) return {16'h0, h};
`endif
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'h00;
        m_instr = 32'h0; m_alu = 32'h0; m_wd = 32'h0; m_pc4 = 32'h0; m_rd = 5'd0;
    endtask

    // one rising edge of the reference: store in M commits, then E moves to M
    task automatic model_edge();
        int a;
        a = baddr(m_alu);
        if (m_instr[31:26] == T_SW) begin
            for (int k = 0; k < 4; k++) mm[(a & ~3) + k] = m_wd[8*k +: 8];
        end
`ifdef PIPELINE_M_BYTE_EN
        if (m_instr[31:26] == T_SB) mm[a] = m_wd[7:0];
        if (m_instr[31:26] == T_SH) begin
            mm[a & ~1]       = m_wd[7:0];
            mm[(a & ~1) + 1] = m_wd[15:8];
        end
`endif
        if (flush) begin
            m_instr = 32'h0; m_alu = 32'h0; m_wd = 32'h0; m_pc4 = 32'h0; m_rd = 5'd0;
        end else begin
            m_instr = instr_e; m_alu = alu_e; m_wd = wd_e; m_pc4 = pc4_e; m_rd = rd_e;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".instr"}, instr_m, m_instr);
        chk({tag, ".alu"},   alu_m,   m_alu);
        chk({tag, ".wd"},    wd_m,    m_wd);
        chk({tag, ".pc4"},   pc4_m,   m_pc4);
        chk({tag, ".rd"},    {27'h0, rd_m}, {27'h0, m_rd});
        chk({tag, ".rdata"}, rdata_m, exp_read());
        chk({tag, ".mw"},    {31'h0, memwrite_m}, {31'h0, is_store(m_instr[31:26])});
    endtask

    task automatic cycle(input string tag, input logic [5:0] op, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rt, input logic fl);
        instr_e = mk(op, rt);
        alu_e   = alu;
        wd_e    = wd;
        rd_e    = rt;
        pc4_e   = $urandom;
        flush   = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [5:0]  ops [10];
        logic [31:0] a;
        ops = '{T_LW, T_SW, T_LW, T_SW, T_ADD, T_LB, T_LBU, T_LH, T_SB, T_SH};

        reset = 1'b1;
        instr_e = 32'h0; alu_e = 32'h0; wd_e = 32'h0; rd_e = 5'd0; pc4_e = 32'h0; flush = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // store then load of the same address
        cycle("sw10", T_SW, 32'h0000_0010, 32'hDEAD_BEEF, 5'd7, 1'b0);
        cycle("lw10", T_LW, 32'h0000_0010, 32'h0, 5'd9, 1'b0);
        chk("swlw.data", rdata_m, 32'hDEAD_BEEF);
        chk("swlw.rd", {27'h0, rd_m}, 32'd9);

        // flushed store never reaches M nor memory
        cycle("sw20f", T_SW, 32'h0000_0020, 32'hCAFE_F00D, 5'd4, 1'b1);
        chk("flush.instr", instr_m, 32'h0);
        chk("flush.mw", {31'h0, memwrite_m}, 32'h0);
        cycle("lw20", T_LW, 32'h0000_0020, 32'h0, 5'd4, 1'b0);
        chk("flush.word8", rdata_m, 32'h0);

        // back-to-back store/load to the same word
        cycle("ov_sw1", T_SW, 32'h0000_0010, 32'h0000_0001, 5'd1, 1'b0);
        cycle("ov_sw2", T_SW, 32'h0000_0010, 32'hA5A5_A5A5, 5'd1, 1'b0);
        cycle("ov_lw",  T_LW, 32'h0000_0010, 32'h0, 5'd2, 1'b0);
        chk("overlap.data", rdata_m, 32'hA5A5_A5A5);

        // misaligned load truncates to the word
        cycle("mis_lw", T_LW, 32'h0000_0013, 32'h0, 5'd2, 1'b0);
        chk("misalign.data", rdata_m, 32'hA5A5_A5A5);

        // address wrap modulo memory size
        cycle("wr_sw", T_SW, 32'h0000_1004, 32'h1234_5678, 5'd5, 1'b0);
        cycle("wr_lw", T_LW, 32'h0000_0004, 32'h0, 5'd5, 1'b0);
        chk("wrap.data", rdata_m, 32'h1234_5678);

        // async reset with a store pending in M
        cycle("rs_sw1", T_SW, 32'h0000_0004, 32'h0000_0077, 5'd6, 1'b0);
        cycle("rs_nop", T_ADD, 32'h0000_0000, 32'h0, 5'd6, 1'b0);
        cycle("rs_sw2", T_SW, 32'h0000_0004, 32'h0000_0088, 5'd6, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.mw", {31'h0, memwrite_m}, 32'h0);
        @(posedge clk);
        #1;
        check_all("rst_hold");
        reset = 1'b0;
        cycle("rs_lw", T_LW, 32'h0000_0004, 32'h0, 5'd6, 1'b0);
        chk("rst.lw4", rdata_m, 32'h0);

`ifdef PIPELINE_M_BYTE_EN
        cycle("b_sw",  T_SW,  32'h0000_0008, 32'h0000_0000, 5'd1, 1'b0);
        cycle("b_sb",  T_SB,  32'h0000_0009, 32'h0000_0080, 5'd1, 1'b0);
        cycle("b_lb",  T_LB,  32'h0000_0009, 32'h0, 5'd2, 1'b0);
        chk("byte.lb", rdata_m, 32'hFFFF_FF80);
        cycle("b_lbu", T_LBU, 32'h0000_0009, 32'h0, 5'd2, 1'b0);
        chk("byte.lbu", rdata_m, 32'h0000_0080);
        cycle("b_lw",  T_LW,  32'h0000_0008, 32'h0, 5'd2, 1'b0);
        chk("byte.lw", rdata_m, 32'h0000_8000);
`endif

        // random traffic over a small window, sometimes with high address bits set
        for (int n = 0; n < 400; n++) begin
            a = MEM_BASE + $urandom_range(0, 127);
            if ($urandom_range(0, 3) == 0) a = a + ($urandom & 32'hFFFF_F000);
            cycle("rnd", ops[$urandom_range(0, 9)], a, $urandom, 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
